// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the EX-stage branch resolve unit: opcode encodings,
// ALU flag bit positions and the squash FSM state encoding.
package branch_resolve_unit_pkg;

  // Opcode encodings, shared with the decoder and ALU control
  localparam logic [4:0] OPC_CMP  = 5'b00101;
  localparam logic [4:0] OPC_BEQ  = 5'b10000;
  localparam logic [4:0] OPC_BGT  = 5'b10001;
  localparam logic [4:0] OPC_B    = 5'b10010;
  localparam logic [4:0] OPC_CALL = 5'b10011;
  localparam logic [4:0] OPC_RET  = 5'b10100;

  localparam int FLAG_GT = 1;
  localparam int FLAG_EQ = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX-stage control-flow bus: instruction/flag inputs from EX, redirect,
// squash and ra write back out to fetch, the pipeline and the regfile arbiter.
interface branch_resolve_unit_if #(
  parameter int ADDR_W = 32,
  parameter int OPC_W  = 5
);
  logic              stall;
  logic              ex_valid;
  logic [OPC_W-1:0]  ex_opcode;
  logic [ADDR_W-1:0] ex_pc;
  logic [ADDR_W-1:0] ex_target;
  logic [ADDR_W-1:0] ex_ra_val;
  logic [1:0]        alu_flags;
  logic [1:0]        flags_q;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              squash;
  logic              ra_we;
  logic [ADDR_W-1:0] ra_wdata;
  logic [15:0]       taken_cnt;

  modport master (
    output stall, ex_valid, ex_opcode, ex_pc, ex_target, ex_ra_val, alu_flags,
    input  flags_q, redirect, redirect_pc, squash, ra_we, ra_wdata, taken_cnt
  );

  modport slave (
    input  stall, ex_valid, ex_opcode, ex_pc, ex_target, ex_ra_val, alu_flags,
    output flags_q, redirect, redirect_pc, squash, ra_we, ra_wdata, taken_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves b/beq/bgt/call/ret in EX against the latched cmp flags, issuing a
// registered redirect, a FLUSH_CYCLES-long squash and the call ra write.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int OPC_W        = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  branch_resolve_unit_if.slave bus
);

  state_t            state;
  logic [2:0]        flush_cnt;
  logic              accept;
  logic              is_cmp;
  logic              is_call;
  logic              is_ret;
  logic              taken;
  logic [ADDR_W-1:0] target;

  assign accept = bus.ex_valid && !bus.stall && (state == IDLE);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    is_cmp  = 1'b0;
    is_call = 1'b0;
    is_ret  = 1'b0;
    taken   = 1'b0;
    case (bus.ex_opcode)
      OPC_W'(OPC_CMP):  is_cmp = 1'b1;
      OPC_W'(OPC_BEQ):  taken  = bus.flags_q[FLAG_EQ];
      OPC_W'(OPC_BGT):  taken  = bus.flags_q[FLAG_GT];
      OPC_W'(OPC_B):    taken  = 1'b1;
      OPC_W'(OPC_CALL): begin
        is_call = 1'b1;
        taken   = 1'b1;
      end
      OPC_W'(OPC_RET): begin
        is_ret = 1'b1;
        taken  = 1'b1;
      end
      default: ;
    endcase
  end

  assign target = is_ret ? bus.ex_ra_val : bus.ex_target;

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      flush_cnt       <= 3'd0;
      bus.flags_q     <= 2'b00;
      bus.redirect    <= 1'b0;
      bus.redirect_pc <= '0;
      bus.squash      <= 1'b0;
      bus.ra_we       <= 1'b0;
      bus.ra_wdata    <= '0;
      bus.taken_cnt   <= 16'd0;
    end else begin
      // Pulses drop after one cycle even when the pipeline is stalled
      bus.redirect <= 1'b0;
      bus.ra_we    <= 1'b0;
      if (!bus.stall) begin
        case (state)
          IDLE: begin
            if (accept) begin
              if (is_cmp) bus.flags_q <= bus.alu_flags;
              if (taken) begin
                bus.redirect    <= 1'b1;
                bus.redirect_pc <= target;
                bus.squash      <= 1'b1;
                bus.taken_cnt   <= bus.taken_cnt + 16'd1;
                flush_cnt       <= 3'(FLUSH_CYCLES);
                state           <= FLUSH;
                if (is_call) begin
                  bus.ra_we    <= 1'b1;
                  bus.ra_wdata <= bus.ex_pc + ADDR_W'(4);
                end
              end
            end
          end
          FLUSH: begin
            if (flush_cnt == 3'd1) begin
              flush_cnt  <= 3'd0;
              bus.squash <= 1'b0;
              state      <= IDLE;
            end else begin
              flush_cnt <= flush_cnt - 3'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scenario bench for branch_resolve_unit: expected redirects are queued when
// a branch is presented and popped by a monitor when redirect is observed.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic        ra_we;
    logic [31:0] ra_wdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  logic [15:0] exp_cnt;
  logic [1:0]  exp_flags;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.ADDR_W(32), .OPC_W(5)) dut_if ();

  branch_resolve_unit #(.ADDR_W(32), .FLUSH_CYCLES(2), .OPC_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if)
  );

  // Scoreboard monitor: every observed redirect / ra write must match the head
  always @(negedge clk) begin
    if (rst_n && (dut_if.redirect || dut_if.ra_we)) begin
      n_checks++;
      if (!dut_if.redirect) begin
        n_fail++;
        $display("FAIL ra_we_alone: ra_we=%b redirect=%b required redirect=1", dut_if.ra_we, dut_if.redirect);
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_redirect: redirect_pc=%h required no redirect", dut_if.redirect_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (dut_if.redirect_pc !== e.pc || dut_if.ra_we !== e.ra_we ||
            (e.ra_we && dut_if.ra_wdata !== e.ra_wdata)) begin
          n_fail++;
          $display("FAIL redirect_match: pc=%h ra_we=%b ra_wdata=%h required pc=%h ra_we=%b ra_wdata=%h",
                   dut_if.redirect_pc, dut_if.ra_we, dut_if.ra_wdata, e.pc, e.ra_we, e.ra_wdata);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one instruction for one cycle; returns at the negedge after the edge
  task automatic present(input logic [4:0] op, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [31:0] ra, input logic [1:0] fl);
    @(negedge clk);
    dut_if.ex_valid  = 1'b1;
    dut_if.ex_opcode = op;
    dut_if.ex_pc     = pc;
    dut_if.ex_target = tgt;
    dut_if.ex_ra_val = ra;
    dut_if.alu_flags = fl;
    @(negedge clk);
    dut_if.ex_valid  = 1'b0;
    dut_if.alu_flags = 2'b00;
  endtask

  task automatic push(input logic [31:0] pc, input logic we, input logic [31:0] wd);
    exp_t e;
    e.pc = pc; e.ra_we = we; e.ra_wdata = wd;
    sb.push_back(e);
    exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    dut_if.stall = 1'b0; dut_if.ex_valid = 1'b0; dut_if.ex_opcode = '0;
    dut_if.ex_pc = '0; dut_if.ex_target = '0; dut_if.ex_ra_val = '0; dut_if.alu_flags = '0;
    exp_cnt = 16'd0; exp_flags = 2'b00;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({dut_if.flags_q, dut_if.redirect, dut_if.redirect_pc, dut_if.squash, dut_if.ra_we, dut_if.ra_wdata, dut_if.taken_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: flags=%b redir=%b pc=%h squash=%b ra_we=%b ra_wdata=%h cnt=%0d required all zero",
               dut_if.flags_q, dut_if.redirect, dut_if.redirect_pc, dut_if.squash, dut_if.ra_we, dut_if.ra_wdata, dut_if.taken_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_beq_taken;
    int sq = 0;
    present(OPC_CMP, 32'h0, 32'h0, 32'h0, 2'b01);
    exp_flags = 2'b01;
    n_checks++;
    if (dut_if.flags_q !== exp_flags) begin n_fail++; $display("FAIL cmp_flags_eq: got %b required %b", dut_if.flags_q, exp_flags); end
    push(32'h80, 1'b0, 32'h0);
    present(OPC_BEQ, 32'h40, 32'h80, 32'h0, 2'b00);
    n_checks++;
    if (dut_if.redirect !== 1'b1) begin n_fail++; $display("FAIL beq_redirect: got %b required 1", dut_if.redirect); end
    n_checks++;
    if (dut_if.taken_cnt !== exp_cnt) begin n_fail++; $display("FAIL beq_taken_cnt: got %0d required %0d", dut_if.taken_cnt, exp_cnt); end
    for (int i = 0; i < 20; i++) begin
      if (!dut_if.squash) break;
      sq++;
      @(negedge clk);
    end
    n_checks++;
    if (sq != 2) begin n_fail++; $display("FAIL beq_squash_len: got %0d required 2", sq); end
  endtask

  task automatic test_beq_not_taken_bgt;
    present(OPC_CMP, 32'h0, 32'h0, 32'h0, 2'b10);
    exp_flags = 2'b10;
    n_checks++;
    if (dut_if.flags_q !== exp_flags) begin n_fail++; $display("FAIL cmp_flags_gt: got %b required %b", dut_if.flags_q, exp_flags); end
    present(OPC_BEQ, 32'h50, 32'h90, 32'h0, 2'b00);
    n_checks++;
    if ({dut_if.redirect, dut_if.squash} !== 2'b00) begin n_fail++; $display("FAIL beq_not_taken: redirect,squash=%b required 00", {dut_if.redirect, dut_if.squash}); end
    n_checks++;
    if (dut_if.taken_cnt !== exp_cnt) begin n_fail++; $display("FAIL beq_not_taken_cnt: got %0d required %0d", dut_if.taken_cnt, exp_cnt); end
    push(32'h100, 1'b0, 32'h0);
    present(OPC_BGT, 32'h54, 32'h100, 32'h0, 2'b00);
    n_checks++;
    if (dut_if.squash !== 1'b1) begin n_fail++; $display("FAIL bgt_squash: got %b required 1", dut_if.squash); end
    for (int i = 0; i < 20; i++) begin
      if (!dut_if.squash) break;
      @(negedge clk);
    end
  endtask

  task automatic test_call_ret;
    push(32'h400, 1'b1, 32'h204);
    present(OPC_CALL, 32'h200, 32'h400, 32'h0, 2'b00);
    n_checks++;
    if ({dut_if.redirect, dut_if.ra_we, dut_if.ra_wdata} !== {1'b1, 1'b1, 32'h204}) begin
      n_fail++;
      $display("FAIL call_ra: redirect=%b ra_we=%b ra_wdata=%h required 1 1 00000204", dut_if.redirect, dut_if.ra_we, dut_if.ra_wdata);
    end
    for (int i = 0; i < 20; i++) begin
      if (!dut_if.squash) break;
      @(negedge clk);
    end
    push(32'h204, 1'b0, 32'h0);
    present(OPC_RET, 32'h404, 32'h999, 32'h204, 2'b00);
    n_checks++;
    if (dut_if.ra_we !== 1'b0) begin n_fail++; $display("FAIL ret_no_ra_we: got %b required 0", dut_if.ra_we); end
    for (int i = 0; i < 20; i++) begin
      if (!dut_if.squash) break;
      @(negedge clk);
    end
    n_checks++;
    if (dut_if.taken_cnt !== exp_cnt) begin n_fail++; $display("FAIL call_ret_cnt: got %0d required %0d", dut_if.taken_cnt, exp_cnt); end
  endtask

  task automatic test_wrong_path;
    push(32'h500, 1'b0, 32'h0);
    present(OPC_B, 32'h480, 32'h500, 32'h0, 2'b00);
    // Wrong-path CMP and B while squash is active
    dut_if.ex_valid = 1'b1; dut_if.ex_opcode = OPC_CMP; dut_if.alu_flags = 2'b01;
    @(negedge clk);
    dut_if.ex_opcode = OPC_B; dut_if.ex_target = 32'h600; dut_if.alu_flags = 2'b00;
    @(negedge clk);
    dut_if.ex_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dut_if.flags_q !== exp_flags) begin n_fail++; $display("FAIL wrong_path_flags: got %b required %b", dut_if.flags_q, exp_flags); end
    n_checks++;
    if (dut_if.taken_cnt !== exp_cnt) begin n_fail++; $display("FAIL wrong_path_cnt: got %0d required %0d", dut_if.taken_cnt, exp_cnt); end
    n_checks++;
    if (dut_if.squash !== 1'b0) begin n_fail++; $display("FAIL wrong_path_squash_end: got %b required 0", dut_if.squash); end
  endtask

  task automatic test_stall;
    int sq = 0;
    push(32'h700, 1'b0, 32'h0);
    present(OPC_B, 32'h680, 32'h700, 32'h0, 2'b00);
    for (int i = 0; i < 20; i++) begin
      if (!dut_if.squash) break;
      sq++;
      dut_if.stall = (i < 3);
      @(negedge clk);
      if (i == 0) begin
        n_checks++;
        if (dut_if.redirect !== 1'b0) begin n_fail++; $display("FAIL stall_redirect_drop: got %b required 0", dut_if.redirect); end
      end
    end
    dut_if.stall = 1'b0;
    n_checks++;
    if (sq != 5) begin n_fail++; $display("FAIL stall_squash_len: got %0d required 5", sq); end
    // Branch and CMP presented under stall in IDLE must be ignored
    dut_if.stall = 1'b1;
    present(OPC_B, 32'h720, 32'h740, 32'h0, 2'b00);
    present(OPC_CMP, 32'h724, 32'h0, 32'h0, 2'b01);
    n_checks++;
    if ({dut_if.redirect, dut_if.squash, dut_if.flags_q} !== {2'b00, exp_flags}) begin
      n_fail++;
      $display("FAIL stall_idle_ignore: redirect=%b squash=%b flags=%b required 0 0 %b", dut_if.redirect, dut_if.squash, dut_if.flags_q, exp_flags);
    end
    n_checks++;
    if (dut_if.taken_cnt !== exp_cnt) begin n_fail++; $display("FAIL stall_idle_cnt: got %0d required %0d", dut_if.taken_cnt, exp_cnt); end
    dut_if.stall = 1'b0;
  endtask

  task automatic test_reset_mid_flush;
    push(32'h800, 1'b0, 32'h0);
    present(OPC_B, 32'h780, 32'h800, 32'h0, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 16'd0; exp_flags = 2'b00;
    n_checks++;
    if ({dut_if.flags_q, dut_if.redirect, dut_if.redirect_pc, dut_if.squash, dut_if.ra_we, dut_if.ra_wdata, dut_if.taken_cnt} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: redir=%b pc=%h squash=%b cnt=%0d flags=%b required all zero",
               dut_if.redirect, dut_if.redirect_pc, dut_if.squash, dut_if.taken_cnt, dut_if.flags_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push(32'h900, 1'b0, 32'h0);
    present(OPC_B, 32'h880, 32'h900, 32'h0, 2'b00);
    n_checks++;
    if ({dut_if.redirect, dut_if.squash, dut_if.taken_cnt} !== {2'b11, exp_cnt}) begin
      n_fail++;
      $display("FAIL post_reset_b: redirect=%b squash=%b cnt=%0d required 1 1 %0d", dut_if.redirect, dut_if.squash, dut_if.taken_cnt, exp_cnt);
    end
    for (int i = 0; i < 20; i++) begin
      if (!dut_if.squash) break;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_beq_not_taken_bgt();
    test_call_ret();
    test_wrong_path();
    test_stall();
    test_reset_mid_flush();
    repeat (2) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d redirects outstanding required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer end of the ALU flag interface: latches the 2-bit {gt, eq} flags produced by cmp in EX and resolves SimpleRISC control-flow instructions (b, beq, bgt, call, ret) against them.
- Drives a registered redirect (target PC) to fetch and a multi-cycle squash of wrong-path instructions.
- Issues the ra (r15) write for call.
- Sits in the EX stage beside the ALU and feeds the IF/ID pipeline registers and the register-file write port arbiter.

Parameters:
- ADDR_W, 32, PC / target / ra width.
- FLUSH_CYCLES, 2, cycles of squash after a taken redirect (range 1..7).
- OPC_W, 5, opcode width; equals the ALU control width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  pipeline hold; freezes all state for the cycle.
- ex_valid  in  1  EX stage holds a live instruction.
- ex_opcode  in  OPC_W  EX instruction opcode.
- ex_pc  in  ADDR_W  PC of the EX instruction.
- ex_target  in  ADDR_W  precomputed PC-relative branch target.
- ex_ra_val  in  ADDR_W  forwarded value of ra, used by ret.
- alu_flags  in  2  ALU flags: [1] gt, [0] eq.
- flags_q  out  2  architectural flags register.
- redirect  out  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  out  ADDR_W  redirect target.
- squash  out  1  IF/ID/EX contents are wrong-path and must be invalidated.
- ra_we  out  1  one-cycle write enable to r15.
- ra_wdata  out  ADDR_W  return address (ex_pc + 4).
- taken_cnt  out  16  count of taken redirects, for performance monitoring.

Behaviour:
- Opcode constants:
  - CMP=00101, BEQ=10000, BGT=10001, B=10010, CALL=10011, RET=10100.
  - All other opcodes are non-control and are ignored.
- Reset (async, rst_n=0) forces:
  - flags_q=00, redirect=0, redirect_pc=0, squash=0, ra_we=0, ra_wdata=0, taken_cnt=0.
  - FSM=IDLE, flush counter=0.
  - Reset asserted mid-FLUSH aborts the flush immediately.
- Accept condition: accept = ex_valid & !stall & (state==IDLE).
  - In FLUSH, ex_valid is ignored; those instructions are wrong-path.
- Flags:
  - On an accepted CMP, flags_q <= alu_flags at the clock edge.
  - Other accepted opcodes leave flags_q unchanged.
  - A branch in the cycle immediately after CMP sees the updated flags_q; no bypass from alu_flags is needed.
- Taken decision, evaluated on accept:
  - B, CALL, RET: always taken.
  - BEQ: taken iff flags_q[0].
  - BGT: taken iff flags_q[1].
- Target selection: RET uses ex_ra_val; all other taken branches use ex_target.
- Latency: decision in cycle T, then at edge T+1 (all outputs registered):
  - redirect=1 and redirect_pc=target, for exactly one cycle.
  - squash=1.
  - FSM -> FLUSH with counter=FLUSH_CYCLES.
  - taken_cnt += 1 (wraps 0xFFFF -> 0).
- CALL additionally pulses ra_we=1 with ra_wdata=ex_pc+4 (modulo 2^ADDR_W) in the same cycle as redirect.
  - The CALL is taken unconditionally, so ra_we never fires without redirect.
- Not-taken BEQ/BGT: no output change and no state change.
- FSM:
  - IDLE -> FLUSH on a taken accept.
  - In FLUSH, squash stays high. When !stall, the counter decrements; on reaching 1, the next edge returns to IDLE with squash=0.
  - squash is therefore high for exactly FLUSH_CYCLES unstalled cycles.
  - While stall=1 in FLUSH, the counter holds and squash stays high.
- Stall:
  - Nothing is accepted and nothing changes, except that the redirect and ra_we pulses still drop after one cycle.
  - Fetch samples redirect regardless of stall.
- flags_q is never modified during FLUSH, even if a wrong-path CMP is presented.

Decomposition:
- Shared package holds:
  - opcode constants CMP/BEQ/BGT/B/CALL/RET (shared with the decoder and the ALU control encoding);
  - flag bit indices FLAG_GT=1, FLAG_EQ=0;
  - FSM state encoding IDLE/FLUSH.
- No sub-module; the flush counter and FSM are small enough to stay inline.

Test Plan:
- CMP with alu_flags=01, then BEQ at pc=0x40, target=0x80 -> flags_q=01 after the CMP edge; redirect=1 with redirect_pc=0x80 one cycle after BEQ accept; squash high 2 cycles; taken_cnt=1.
- CMP with alu_flags=10, then BEQ -> no redirect, squash stays 0; a following BGT with target=0x100 -> redirect_pc=0x100.
- CALL at pc=0x200, target=0x400 -> ra_we=1, ra_wdata=0x204, redirect_pc=0x400, all in the same cycle; then RET with ex_ra_val=0x204 -> redirect_pc=0x204.
- Taken B followed by a wrong-path CMP (alu_flags=01) and a wrong-path B during squash -> flags_q unchanged; only one redirect; taken_cnt increments by 1.
- stall=1 for 3 cycles during FLUSH -> squash stays high for 2+3 cycles total; a branch presented with stall=1 in IDLE -> not accepted.
- rst_n pulsed low mid-FLUSH -> all outputs 0 asynchronously; after release, a B is accepted in the first cycle and redirects normally.
